// File: rtl/spi_pkg.sv
// Shared definitions for the SPI LED-strip transmitter: shifter states,
// default geometry and counter-width helper.
package spi_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_HALF_PERIOD = 40;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACTIVE = 2'b10
    } shift_state_t;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer: start (re)arms it; done is high on the last cycle of a
// HALF_PERIOD-cycle phase, so the caller transitions on that edge.
module spi_half_period_timer
    import spi_pkg::*;
#(
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int             CW   = cnt_width(HALF_PERIOD);
    localparam logic [CW-1:0]  LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] r_count;

    // Saturates at LAST so the count can never wrap inside a phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= '0;
        end else if (r_count != LAST) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign done = (r_count == LAST);

endmodule

// File: rtl/spi_stream_tx.sv
// Word-stream to SPI serializer for LED strips, with a one-entry holding
// buffer so consecutive words go out back-to-back.
module spi_stream_tx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int HALF_PERIOD = DEFAULT_HALF_PERIOD,
    parameter int MSB_FIRST   = 1,
    parameter int CPOL        = 0
) (
    input  logic                  spi_clk,
    input  logic                  spi_reset,
    input  logic [DATA_WIDTH-1:0] spi_data_in,
    input  logic                  spi_valid,
    output logic                  spi_ready,
    output logic                  spi_output_data,
    output logic                  spi_output_clock,
    output logic                  spi_busy
);

    localparam int            BW       = cnt_width(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic          IDLE_CLK = (CPOL != 0);

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
    endfunction

    shift_state_t          r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next, w_shift_adv;
    logic [BW-1:0]         r_bit_cnt, w_bit_cnt_next;
    logic                  r_buf_full, w_buf_full_next;
    logic                  r_ready;
    logic                  r_data, w_data_next;
    logic                  r_clk, w_clk_next;
    logic                  w_accept, w_load, w_last_bit;
    logic                  w_tmr_start, w_tmr_done;

    assign w_accept    = spi_valid & r_ready;
    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_shift_adv = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);

    spi_half_period_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_timer (
        .clk   (spi_clk),
        .rst   (spi_reset),
        .start (w_tmr_start),
        .done  (w_tmr_done)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_data_next    = r_data;
        w_clk_next     = r_clk;
        w_bit_cnt_next = r_bit_cnt;
        w_load         = 1'b0;
        w_tmr_start    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = r_buf_full;
            end
            ST_SETUP: begin
                if (w_tmr_done) begin
                    w_state_next = ST_ACTIVE;
                    w_clk_next   = ~IDLE_CLK;
                    w_tmr_start  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_tmr_done) begin
                    w_clk_next = IDLE_CLK;
                    if (!w_last_bit) begin
                        w_bit_cnt_next = r_bit_cnt + BW'(1);
                        w_shift_next   = w_shift_adv;
                        w_data_next    = first_bit(w_shift_adv);
                        w_state_next   = ST_SETUP;
                        w_tmr_start    = 1'b1;
                    end else if (r_buf_full) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_next   = ST_IDLE;
                        w_data_next    = 1'b0;
                        w_bit_cnt_next = '0;
                    end
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_data_next    = 1'b0;
                w_clk_next     = IDLE_CLK;
                w_bit_cnt_next = '0;
            end
        endcase
        // Loading from the buffer overrides whatever the phase logic chose.
        if (w_load) begin
            w_state_next   = ST_SETUP;
            w_shift_next   = r_buf;
            w_data_next    = first_bit(r_buf);
            w_clk_next     = IDLE_CLK;
            w_bit_cnt_next = '0;
            w_tmr_start    = 1'b1;
        end
    end

    assign w_buf_full_next = w_accept | (r_buf_full & ~w_load);

    always_ff @(posedge spi_clk or posedge spi_reset) begin
        if (spi_reset) begin
            r_state    <= ST_IDLE;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_ready    <= 1'b0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_data     <= 1'b0;
            r_clk      <= IDLE_CLK;
        end else begin
            r_state    <= w_state_next;
            r_buf_full <= w_buf_full_next;
            r_ready    <= ~w_buf_full_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_data     <= w_data_next;
            r_clk      <= w_clk_next;
            if (w_accept) begin
                r_buf <= spi_data_in;
            end
        end
    end

    assign spi_ready        = r_ready;
    assign spi_output_data  = r_data;
    assign spi_output_clock = r_clk;
    assign spi_busy         = r_buf_full | (r_state != ST_IDLE);

endmodule
